// File: rtl/seg7_pkg.sv
// Character codes, segment decode and message ROM for the 7-segment scanner.
package seg7_pkg;

    localparam int unsigned CHAR_W      = 6;
    localparam int unsigned SEG_W       = 7;
    localparam int unsigned MSG_ROM_N   = 16;
    localparam int unsigned MSG_ROM_LEN = 8;

    typedef logic [CHAR_W-1:0] char_t;

    localparam char_t CH_0     = 6'd0;
    localparam char_t CH_1     = 6'd1;
    localparam char_t CH_2     = 6'd2;
    localparam char_t CH_3     = 6'd3;
    localparam char_t CH_4     = 6'd4;
    localparam char_t CH_5     = 6'd5;
    localparam char_t CH_6     = 6'd6;
    localparam char_t CH_7     = 6'd7;
    localparam char_t CH_8     = 6'd8;
    localparam char_t CH_9     = 6'd9;
    localparam char_t CH_A     = 6'd10;
    localparam char_t CH_C     = 6'd11;
    localparam char_t CH_D     = 6'd12;
    localparam char_t CH_E     = 6'd13;
    localparam char_t CH_L     = 6'd14;
    localparam char_t CH_N     = 6'd15;
    localparam char_t CH_O     = 6'd16;
    localparam char_t CH_P     = 6'd17;
    localparam char_t CH_R     = 6'd18;
    localparam char_t CH_S     = 6'd19;
    localparam char_t CH_T     = 6'd20;
    localparam char_t CH_U     = 6'd21;
    localparam char_t CH_BLANK = 6'd63;

    // Capital O is shown with the digit-0 glyph; CH_O is the lowercase o.
    localparam char_t MSG_ROM [MSG_ROM_N][MSG_ROM_LEN] = '{
        '{CH_C, CH_E, CH_0, CH_1, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
        '{CH_C, CH_E, CH_0, CH_2, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
        '{CH_C, CH_E, CH_0, CH_3, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
        '{CH_P, CH_R, CH_0, CH_N, CH_T,     CH_O,     CH_BLANK, CH_BLANK},
        '{CH_E, CH_R, CH_R, CH_0, CH_BLANK, CH_BLANK, CH_BLANK, CH_BLANK},
        '{default: CH_BLANK},
        '{default: CH_BLANK},
        '{default: CH_BLANK},
        '{default: CH_BLANK},
        '{default: CH_BLANK},
        '{default: CH_BLANK},
        '{default: CH_BLANK},
        '{default: CH_BLANK},
        '{default: CH_BLANK},
        '{default: CH_BLANK},
        '{default: CH_BLANK}
    };

    // Active-high segment pattern {a,b,c,d,e,f,g} for a character code.
    function automatic logic [SEG_W-1:0] char_to_seg(input char_t ch);
        logic [SEG_W-1:0] s;
        case (ch)
            CH_0:    s = 7'b1111110;
            CH_1:    s = 7'b0110000;
            CH_2:    s = 7'b1101101;
            CH_3:    s = 7'b1111001;
            CH_4:    s = 7'b0110011;
            CH_5:    s = 7'b1011011;
            CH_6:    s = 7'b1011111;
            CH_7:    s = 7'b1110000;
            CH_8:    s = 7'b1111111;
            CH_9:    s = 7'b1111011;
            CH_A:    s = 7'b1110111;
            CH_C:    s = 7'b1001110;
            CH_D:    s = 7'b0111101;
            CH_E:    s = 7'b1001111;
            CH_L:    s = 7'b0001110;
            CH_N:    s = 7'b0010101;
            CH_O:    s = 7'b0011101;
            CH_P:    s = 7'b1100111;
            CH_R:    s = 7'b0000101;
            CH_S:    s = 7'b1011011;
            CH_T:    s = 7'b0001111;
            CH_U:    s = 7'b0111110;
            default: s = 7'b0000000;
        endcase
        return s;
    endfunction

    // ROM character lookup; callers range-check before truncating indices.
    function automatic char_t rom_char(input logic [3:0] msg, input logic [2:0] idx);
        return MSG_ROM[msg][idx];
    endfunction

endpackage

// File: rtl/seg7_scan_timer.sv
// Prescaled digit scan counter with frame-wrap strobe.
module seg7_scan_timer #(
    parameter int unsigned N_DIGITS = 4,
    parameter int unsigned PRESCALE = 50000,
    localparam int unsigned SCAN_W  = $clog2(N_DIGITS)
) (
    input  logic              clock,
    input  logic              reset,
    output logic [SCAN_W-1:0] scan_idx,
    output logic              frame_wrap_c,
    output logic              frame_tick
);

    localparam int unsigned PRE_W = $clog2(PRESCALE);

    logic [PRE_W-1:0]  prescaler_q, prescaler_d;
    logic [SCAN_W-1:0] scan_idx_q, scan_idx_d;
    logic              frame_tick_q, frame_tick_d;
    logic              step_c;

    // Prescaler wrap produces a scan step; last digit on a step is the frame wrap.
    always_comb begin
        step_c       = (prescaler_q == PRE_W'(PRESCALE - 1));
        frame_wrap_c = step_c && (scan_idx_q == SCAN_W'(N_DIGITS - 1));
        prescaler_d  = step_c ? '0 : prescaler_q + PRE_W'(1);
        scan_idx_d   = scan_idx_q;
        if (step_c) begin
            scan_idx_d = frame_wrap_c ? '0 : scan_idx_q + SCAN_W'(1);
        end
        frame_tick_d = frame_wrap_c;
    end

    // Timer state registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            prescaler_q  <= '0;
            scan_idx_q   <= '0;
            frame_tick_q <= 1'b0;
        end else begin
            prescaler_q  <= prescaler_d;
            scan_idx_q   <= scan_idx_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign scan_idx   = scan_idx_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: rtl/seg7_message_scanner.sv
// Multiplexed 7-segment message display with blink and scroll modes.
module seg7_message_scanner
    import seg7_pkg::*;
#(
    parameter int unsigned N_DIGITS       = 4,
    parameter int unsigned PRESCALE       = 50000,
    parameter int unsigned N_MSG          = 16,
    parameter int unsigned MSG_LEN        = 8,
    parameter int unsigned BLINK_FRAMES   = 64,
    parameter int unsigned SCROLL_FRAMES  = 128,
    parameter int unsigned SEG_ACTIVE_LOW = 0,
    localparam int unsigned MSG_W         = (N_MSG > 1) ? $clog2(N_MSG) : 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [MSG_W-1:0]    msg_sel,
    input  logic                msg_valid,
    input  logic                blink_en,
    input  logic                scroll_en,
    output logic [6:0]          seg,
    output logic [N_DIGITS-1:0] digit_en,
    output logic                frame_tick
);

    localparam int unsigned SCAN_W = $clog2(N_DIGITS);
    localparam int unsigned OFF_W  = $clog2(MSG_LEN);
    localparam int unsigned BCNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
    localparam int unsigned SCNT_W = (SCROLL_FRAMES > 1) ? $clog2(SCROLL_FRAMES) : 1;
    localparam logic [6:0]          SEG_OFF = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic [N_DIGITS-1:0] DIG_OFF = (SEG_ACTIVE_LOW != 0) ? {N_DIGITS{1'b1}} : '0;

    logic [SCAN_W-1:0]   scan_idx;
    logic                frame_wrap_c;

    logic [OFF_W-1:0]    offset_q, offset_d;
    logic [SCNT_W-1:0]   scroll_cnt_q, scroll_cnt_d;
    logic [BCNT_W-1:0]   blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    logic [MSG_W-1:0]    prev_sel_q;
    logic                prev_valid_q;
    logic [6:0]          seg_q, seg_d;
    logic [N_DIGITS-1:0] digit_en_q, digit_en_d;

    logic                valid_eff_c;
    logic                msg_change_c;
    int unsigned         char_pos;
    char_t               ch_c;
    logic [6:0]          seg_raw_c;

    seg7_scan_timer #(
        .N_DIGITS (N_DIGITS),
        .PRESCALE (PRESCALE)
    ) u_scan_timer (
        .clock        (clock),
        .reset        (reset),
        .scan_idx     (scan_idx),
        .frame_wrap_c (frame_wrap_c),
        .frame_tick   (frame_tick)
    );

    // Message-change detect, blink/scroll frame counters and output decode.
    always_comb begin
        valid_eff_c  = msg_valid && (32'(msg_sel) < N_MSG);
        msg_change_c = (msg_sel != prev_sel_q) || (valid_eff_c && !prev_valid_q);

        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (msg_change_c || !blink_en) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b1;
        end else if (frame_wrap_c) begin
            if (blink_cnt_q == BCNT_W'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = '0;
                blink_phase_d = !blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + BCNT_W'(1);
            end
        end

        scroll_cnt_d = scroll_cnt_q;
        offset_d     = offset_q;
        if (msg_change_c || !scroll_en) begin
            scroll_cnt_d = '0;
            offset_d     = '0;
        end else if (frame_wrap_c) begin
            if (scroll_cnt_q == SCNT_W'(SCROLL_FRAMES - 1)) begin
                scroll_cnt_d = '0;
                offset_d     = (offset_q == OFF_W'(MSG_LEN - 1)) ? '0 : offset_q + OFF_W'(1);
            end else begin
                scroll_cnt_d = scroll_cnt_q + SCNT_W'(1);
            end
        end

        // Both terms are below MSG_LEN, so one conditional subtract is a full modulo.
        char_pos = 32'(offset_q) + 32'(scan_idx);
        if (char_pos >= MSG_LEN) begin
            char_pos = char_pos - MSG_LEN;
        end

        ch_c = CH_BLANK;
        if ((32'(msg_sel) < MSG_ROM_N) && (char_pos < MSG_ROM_LEN)) begin
            ch_c = rom_char(4'(msg_sel), 3'(char_pos));
        end

        seg_raw_c = '0;
        if (valid_eff_c && !(blink_en && !blink_phase_q)) begin
            seg_raw_c = char_to_seg(ch_c);
        end

        seg_d      = (SEG_ACTIVE_LOW != 0) ? ~seg_raw_c : seg_raw_c;
        digit_en_d = N_DIGITS'(1) << scan_idx;
        if (SEG_ACTIVE_LOW != 0) begin
            digit_en_d = ~digit_en_d;
        end
    end

    // Message, mode and output registers.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            offset_q      <= '0;
            scroll_cnt_q  <= '0;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b1;
            prev_sel_q    <= '0;
            prev_valid_q  <= 1'b0;
            seg_q         <= SEG_OFF;
            digit_en_q    <= DIG_OFF;
        end else begin
            offset_q      <= offset_d;
            scroll_cnt_q  <= scroll_cnt_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            prev_sel_q    <= msg_sel;
            prev_valid_q  <= valid_eff_c;
            seg_q         <= seg_d;
            digit_en_q    <= digit_en_d;
        end
    end

    assign seg      = seg_q;
    assign digit_en = digit_en_q;

endmodule

// File: tb/tb_seg7_message_scanner.sv
// Scoreboard bench for seg7_message_scanner with a frame-count reference model.
module tb_seg7_message_scanner;

    localparam int P  = 4;
    localparam int ND = 4;
    localparam int ML = 8;
    localparam int BF = 2;
    localparam int SF = 1;

    logic       clock = 1'b0;
    logic       reset;
    logic [3:0] msg_sel;
    logic       msg_valid;
    logic       blink_en;
    logic       scroll_en;
    logic [6:0] seg;
    logic [3:0] digit_en;
    logic       frame_tick;

    seg7_message_scanner #(
        .N_DIGITS       (ND),
        .PRESCALE       (P),
        .N_MSG          (16),
        .MSG_LEN        (ML),
        .BLINK_FRAMES   (BF),
        .SCROLL_FRAMES  (SF),
        .SEG_ACTIVE_LOW (0)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .msg_sel    (msg_sel),
        .msg_valid  (msg_valid),
        .blink_en   (blink_en),
        .scroll_en  (scroll_en),
        .seg        (seg),
        .digit_en   (digit_en),
        .frame_tick (frame_tick)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [6:0] seg;
        logic [3:0] dig;
        logic       ft;
    } exp_t;

    exp_t  exp_q[$];
    exp_t  mon_e;
    int    n_cmp = 0;
    int    n_err = 0;
    int    n_pop = 0;
    string msgs[16];

    // Model state: edges since reset, frames counted since the last scroll/blink restart.
    int         t = 0;
    int         sfr = 0;
    int         bfr = 0;
    logic [3:0] last_sel = 4'd0;
    logic       last_valid = 1'b0;

    initial begin
        msgs[0] = "CE01    ";
        msgs[1] = "CE02    ";
        msgs[2] = "CE03    ";
        msgs[3] = "PrOnto  ";
        msgs[4] = "ErrO    ";
        for (int i = 5; i < 16; i++) msgs[i] = "        ";
    end

    function automatic logic [6:0] ascii_seg(input byte c);
        case (c)
            "C": return 7'b1001110;
            "E": return 7'b1001111;
            "0": return 7'b1111110;
            "O": return 7'b1111110;
            "1": return 7'b0110000;
            "2": return 7'b1101101;
            "3": return 7'b1111001;
            "P": return 7'b1100111;
            "r": return 7'b0000101;
            "n": return 7'b0010101;
            "t": return 7'b0001111;
            "o": return 7'b0011101;
            default: return 7'b0000000;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, want, $time);
        end
    endtask

    // Reference model: predicts the outputs produced by each clock edge.
    always @(posedge clock or posedge reset) begin
        if (reset) begin
            t = 0; sfr = 0; bfr = 0;
            last_sel = 4'd0; last_valid = 1'b0;
            exp_q.delete();
        end else begin
            int   scan, off, pos;
            bit   vis, wrap, change;
            exp_t e;
            byte  c;
            scan   = (t / P) % ND;
            off    = (sfr / SF) % ML;
            vis    = ((bfr / BF) % 2) == 0;
            wrap   = ((t + 1) % (P * ND)) == 0;
            change = (msg_sel != last_sel) || (msg_valid && !last_valid);
            pos    = (off + scan) % ML;
            c      = msgs[msg_sel][pos];
            e.seg  = (!msg_valid || (blink_en && !vis)) ? 7'b0 : ascii_seg(c);
            e.dig  = 4'(1 << scan);
            e.ft   = wrap;
            exp_q.push_back(e);
            if (change || !scroll_en) sfr = 0; else if (wrap) sfr++;
            if (change || !blink_en)  bfr = 0; else if (wrap) bfr++;
            last_sel   = msg_sel;
            last_valid = msg_valid;
            t++;
        end
    end

    // Monitor: compare DUT outputs against the oldest prediction.
    always @(negedge clock) begin
        if (!reset && exp_q.size() != 0) begin
            mon_e = exp_q.pop_front();
            n_pop++;
            check("seg", 32'(seg), 32'(mon_e.seg));
            check("digit_en", 32'(digit_en), 32'(mon_e.dig));
            check("frame_tick", 32'(frame_tick), 32'(mon_e.ft));
        end
    end

    task automatic hold(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic set_in(input int sel, input bit v, input bit b, input bit s);
        msg_sel   = 4'(sel);
        msg_valid = v;
        blink_en  = b;
        scroll_en = s;
    endtask

    initial begin
        reset = 1'b1;
        set_in(0, 1'b1, 1'b0, 1'b0);
        #2;
        check("reset_seg", 32'(seg), 32'd0);
        check("reset_digit_en", 32'(digit_en), 32'd0);
        check("reset_frame_tick", 32'(frame_tick), 32'd0);
        hold(2);
        reset = 1'b0;

        // Scan and message 0.
        hold(40);
        // Blanking by msg_valid=0, then the blank ROM entry.
        set_in(0, 1'b0, 1'b0, 1'b0); hold(20);
        set_in(15, 1'b1, 1'b0, 1'b0); hold(20);
        // Blink on message 1.
        set_in(1, 1'b1, 1'b1, 1'b0); hold(100);
        // Scroll message 3 past the offset wrap, then switch to message 4.
        set_in(3, 1'b1, 1'b0, 1'b1); hold(150);
        set_in(4, 1'b1, 1'b0, 1'b1); hold(70);

        // Asynchronous reset between edges, mid-frame.
        set_in(0, 1'b1, 1'b0, 1'b0); hold(6);
        #2;
        reset = 1'b1;
        #1;
        check("async_seg", 32'(seg), 32'd0);
        check("async_digit_en", 32'(digit_en), 32'd0);
        check("async_frame_tick", 32'(frame_tick), 32'd0);
        hold(2);
        reset = 1'b0;
        hold(20);

        // Randomized mode and message mix.
        for (int k = 0; k < 50; k++) begin
            int sel;
            sel = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, 4)) : int'($urandom_range(0, 15));
            set_in(sel, $urandom_range(0, 7) != 0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            hold(int'($urandom_range(10, 80)));
        end

        hold(3);
        check("scoreboard_activity", 32'(n_pop >= 800), 32'd1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
